// File: rtl/ip_checksum_stream.sv
// Streaming RFC 1071 Internet checksum engine: byte-enabled beats, frame seed,
// three registered stages (beat sum, accumulate, result) and one strobe per frame.
module ip_checksum_stream #(
  parameter int DATA_BYTES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    dv,
  input  logic                    sof,
  input  logic                    eof,
  input  logic [8*DATA_BYTES-1:0] data,
  input  logic [DATA_BYTES-1:0]   keep,
  input  logic [15:0]             seed,
  output logic                    checksum_valid,
  output logic [15:0]             checksum,
  output logic                    csum_ok,
  output logic [15:0]             byte_count
);

  function automatic logic [15:0] fold17(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

  // Two passes are enough: after the first, a carry implies a tiny low half.
  function automatic logic [15:0] fold20(input logic [19:0] s);
    logic [16:0] f;
    f = {1'b0, s[15:0]} + {13'd0, s[19:16]};
    return f[15:0] + {15'd0, f[16]};
  endfunction

  function automatic logic [3:0] popcount(input logic [DATA_BYTES-1:0] k);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      n = n + {3'd0, k[i]};
    end
    return n;
  endfunction

  logic        in_frame_q, in_frame_d;
  logic        odd_q, odd_d;
  logic        accept_s, start_odd_s;
  logic [19:0] raw_sum_s;
  logic [15:0] folded_s, beat_sum_s;
  logic [3:0]  pop_s;

  logic        s1_valid_q, s1_sof_q, s1_eof_q;
  logic [15:0] s1_seed_q, s1_sum_q;
  logic [3:0]  s1_pop_q;

  logic [15:0] acc_q, acc_d, cnt_q, cnt_d;
  logic        s2_eof_q;

  logic        valid_q, ok_q;
  logic [15:0] csum_q, bc_q;

  // Beat acceptance, framing/parity next state and the folded beat sum.
  always_comb begin
    accept_s    = dv & (sof | in_frame_q);
    pop_s       = popcount(keep);
    start_odd_s = sof ? 1'b0 : odd_q;
    raw_sum_s   = 20'd0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      raw_sum_s = raw_sum_s + (!keep[i] ? 20'd0 :
                  (((DATA_BYTES - 1 - i) % 2) == 0) ? {4'd0, data[8*i +: 8], 8'd0}
                                                    : {12'd0, data[8*i +: 8]});
    end
    folded_s   = fold20(raw_sum_s);
    // A beat starting at an odd frame offset has its lanes in the opposite byte positions.
    beat_sum_s = start_odd_s ? {folded_s[7:0], folded_s[15:8]} : folded_s;
    if (accept_s) begin
      in_frame_d = ~eof;
      odd_d      = start_odd_s ^ pop_s[0];
    end else begin
      in_frame_d = in_frame_q;
      odd_d      = odd_q;
    end
  end

  // Framing state and stage 1 beat register.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_frame_q <= 1'b0;
      odd_q      <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_sof_q   <= 1'b0;
      s1_eof_q   <= 1'b0;
      s1_seed_q  <= 16'd0;
      s1_sum_q   <= 16'd0;
      s1_pop_q   <= 4'd0;
    end else begin
      in_frame_q <= in_frame_d;
      odd_q      <= odd_d;
      s1_valid_q <= accept_s;
      if (accept_s) begin
        s1_sof_q  <= sof;
        s1_eof_q  <= eof;
        s1_seed_q <= seed;
        s1_sum_q  <= beat_sum_s;
        s1_pop_q  <= pop_s;
      end
    end
  end

  // Stage 2 accumulate next state: a tagged sof restarts from the seed.
  always_comb begin
    acc_d = fold17(s1_sof_q ? s1_seed_q : acc_q, s1_sum_q);
    cnt_d = (s1_sof_q ? 16'd0 : cnt_q) + {12'd0, s1_pop_q};
  end

  // Stage 2 accumulator and stage 3 result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q    <= 16'd0;
      cnt_q    <= 16'd0;
      s2_eof_q <= 1'b0;
      valid_q  <= 1'b0;
      csum_q   <= 16'd0;
      ok_q     <= 1'b0;
      bc_q     <= 16'd0;
    end else begin
      if (s1_valid_q) begin
        acc_q <= acc_d;
        cnt_q <= cnt_d;
      end
      s2_eof_q <= s1_valid_q & s1_eof_q;
      valid_q  <= s2_eof_q;
      if (s2_eof_q) begin
        csum_q <= ~acc_q;
        ok_q   <= (acc_q == 16'hFFFF);
        bc_q   <= cnt_q;
      end
    end
  end

  assign checksum_valid = valid_q;
  assign checksum       = csum_q;
  assign csum_ok        = ok_q;
  assign byte_count     = bc_q;

endmodule

// File: tb/tb_ip_checksum_stream.sv
// Self-checking bench for ip_checksum_stream (4-byte and 1-byte instances)
// against a frame-level byte-stream checksum model.
module tb_ip_checksum_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        dv4 = 1'b0, sof4 = 1'b0, eof4 = 1'b0;
  logic [31:0] data4 = 32'd0;
  logic [3:0]  keep4 = 4'd0;
  logic [15:0] seed4 = 16'd0;
  logic        cv4, ok4;
  logic [15:0] cs4, bc4;

  logic        dv1 = 1'b0, sof1 = 1'b0, eof1 = 1'b0;
  logic [7:0]  data1 = 8'd0;
  logic [0:0]  keep1 = 1'b0;
  logic [15:0] seed1 = 16'd0;
  logic        cv1, ok1;
  logic [15:0] cs1, bc1;

  ip_checksum_stream #(.DATA_BYTES(4)) u_dut4 (
    .clk(clk), .reset(reset), .dv(dv4), .sof(sof4), .eof(eof4), .data(data4),
    .keep(keep4), .seed(seed4), .checksum_valid(cv4), .checksum(cs4),
    .csum_ok(ok4), .byte_count(bc4)
  );

  ip_checksum_stream #(.DATA_BYTES(1)) u_dut1 (
    .clk(clk), .reset(reset), .dv(dv1), .sof(sof1), .eof(eof1), .data(data1),
    .keep(keep1), .seed(seed1), .checksum_valid(cv1), .checksum(cs1),
    .csum_ok(ok1), .byte_count(bc1)
  );

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct {
    int          id;
    int          cyc;
    logic [15:0] cs;
    logic        ok;
    logic [15:0] bc;
  } exp_t;
  exp_t exp_q[$];

  logic              m_in   [2];
  longint unsigned   m_sum  [2];
  int                m_cnt  [2];
  logic [15:0]       last_cs[2];
  logic              last_ok[2];
  logic [15:0]       last_bc[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  function automatic logic [15:0] ones_fold(input longint unsigned s);
    longint unsigned v;
    v = s;
    while ((v >> 16) != 0) v = (v & 64'hFFFF) + (v >> 16);
    return v[15:0];
  endfunction

  // Frame model: the checksum is the complement of the one's-complement sum of
  // the seed and the frame's bytes taken pairwise in network order.
  task automatic model(input int id, input int db, input logic v, input logic s, input logic e,
                       input logic [63:0] d, input logic [7:0] k, input logic [15:0] sd);
    exp_t        ex;
    logic [7:0]  b;
    logic [15:0] sum;
    if (v) begin
      if (s) begin
        m_in[id]  = 1'b1;
        m_sum[id] = 64'(sd);
        m_cnt[id] = 0;
      end
      if (m_in[id]) begin
        for (int i = db - 1; i >= 0; i--) begin
          if (k[i]) begin
            b = d[8*i +: 8];
            m_sum[id] += ((m_cnt[id] % 2) == 0) ? (64'(b) << 8) : 64'(b);
            m_cnt[id]++;
          end
        end
        if (e) begin
          sum    = ones_fold(m_sum[id]);
          ex.id  = id;
          ex.cyc = cyc + 3;
          ex.cs  = ~sum;
          ex.ok  = (~sum == 16'h0000);
          ex.bc  = 16'(m_cnt[id]);
          exp_q.push_back(ex);
          m_in[id] = 1'b0;
        end
      end
    end
  endtask

  task automatic check_dut(input int id, input logic cv, input logic [15:0] cs,
                           input logic ok, input logic [15:0] bc);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].id == id && exp_q[i].cyc == cyc) begin
        last_cs[id] = exp_q[i].cs;
        last_ok[id] = exp_q[i].ok;
        last_bc[id] = exp_q[i].bc;
        hit = 1'b1;
        exp_q.delete(i);
        break;
      end
    end
    chk($sformatf("valid%0d", id), {31'd0, cv}, {31'd0, hit});
    chk($sformatf("checksum%0d", id), {16'd0, cs}, {16'd0, last_cs[id]});
    chk($sformatf("csum_ok%0d", id), {31'd0, ok}, {31'd0, last_ok[id]});
    chk($sformatf("byte_count%0d", id), {16'd0, bc}, {16'd0, last_bc[id]});
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    check_dut(0, cv4, cs4, ok4, bc4);
    check_dut(1, cv1, cs1, ok1, bc1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      dv4 = 1'b0; sof4 = 1'($urandom); eof4 = 1'($urandom);
      data4 = $urandom; keep4 = 4'($urandom);
      dv1 = 1'b0; sof1 = 1'($urandom); eof1 = 1'($urandom);
      data1 = 8'($urandom); keep1 = 1'($urandom);
      tick();
    end
  endtask

  task automatic beat4(input logic s, input logic e, input logic [31:0] d,
                       input logic [3:0] k, input logic [15:0] sd);
    dv4 = 1'b1; sof4 = s; eof4 = e; data4 = d; keep4 = k; seed4 = sd;
    model(0, 4, 1'b1, s, e, {32'd0, d}, {4'd0, k}, sd);
    tick();
    dv4 = 1'b0;
  endtask

  task automatic beat1(input logic s, input logic e, input logic [7:0] d,
                       input logic k, input logic [15:0] sd);
    dv1 = 1'b1; sof1 = s; eof1 = e; data1 = d; keep1 = k; seed1 = sd;
    model(1, 1, 1'b1, s, e, {56'd0, d}, {7'd0, k}, sd);
    tick();
    dv1 = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; dv4 = 1'b0; dv1 = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 2; i++) begin
      m_in[i] = 1'b0; m_sum[i] = 64'd0; m_cnt[i] = 0;
      last_cs[i] = 16'd0; last_ok[i] = 1'b0; last_bc[i] = 16'd0;
    end
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [3:0] top_keep(input int n);
    int m;
    m = ((1 << n) - 1) << (4 - n);
    return 4'(m);
  endfunction

  int          nb, nk;
  logic [15:0] rs;

  initial begin
    // Reset state and idle garbage with dv low
    do_reset();
    idle(2);

    // IPv4 header generate
    beat4(1'b1, 1'b0, 32'h45000073, 4'hF, 16'h0000);
    beat4(1'b0, 1'b0, 32'h00004000, 4'hF, 16'h0000);
    beat4(1'b0, 1'b0, 32'h40110000, 4'hF, 16'h0000);
    beat4(1'b0, 1'b0, 32'hc0a80001, 4'hF, 16'h0000);
    beat4(1'b0, 1'b1, 32'hc0a800c7, 4'hF, 16'h0000);
    idle(3);
    chk("ipv4_checksum", {16'd0, cs4}, 32'h0000B861);
    chk("ipv4_byte_count", {16'd0, bc4}, 32'd20);
    chk("ipv4_csum_ok", {31'd0, ok4}, 32'd0);

    // Verify with the checksum inserted
    beat4(1'b1, 1'b0, 32'h45000073, 4'hF, 16'h0000);
    beat4(1'b0, 1'b0, 32'h00004000, 4'hF, 16'h0000);
    beat4(1'b0, 1'b0, 32'h4011b861, 4'hF, 16'h0000);
    beat4(1'b0, 1'b0, 32'hc0a80001, 4'hF, 16'h0000);
    beat4(1'b0, 1'b1, 32'hc0a800c7, 4'hF, 16'h0000);
    idle(3);
    chk("verify_checksum", {16'd0, cs4}, 32'h00000000);
    chk("verify_csum_ok", {31'd0, ok4}, 32'd1);

    // Misalignment across beats, 4-byte and 1-byte widths
    beat4(1'b1, 1'b0, 32'h010203AA, 4'b1110, 16'h0000);
    beat4(1'b0, 1'b1, 32'h04050607, 4'hF, 16'h0000);
    idle(3);
    chk("misalign4_checksum", {16'd0, cs4}, 32'h0000EFF3);
    chk("misalign4_byte_count", {16'd0, bc4}, 32'd7);
    for (int i = 1; i <= 7; i++) beat1(i == 1, i == 7, 8'(i), 1'b1, 16'h0000);
    idle(3);
    chk("misalign1_checksum", {16'd0, cs1}, 32'h0000EFF3);
    chk("misalign1_byte_count", {16'd0, bc1}, 32'd7);

    // End-around carry with seed
    beat4(1'b1, 1'b1, 32'hFFFF0001, 4'hF, 16'hFFFF);
    idle(3);
    chk("carry_checksum", {16'd0, cs4}, 32'h0000FFFE);

    // Back-to-back single-beat frames
    beat4(1'b1, 1'b1, 32'h00010002, 4'hF, 16'h0000);
    beat4(1'b1, 1'b1, 32'hFFFFFFFF, 4'hF, 16'h0000);
    tick();
    chk("b2b_a_valid", {31'd0, cv4}, 32'd1);
    chk("b2b_a_checksum", {16'd0, cs4}, 32'h0000FFFC);
    tick();
    chk("b2b_b_valid", {31'd0, cv4}, 32'd1);
    chk("b2b_b_checksum", {16'd0, cs4}, 32'h00000000);
    idle(2);

    // Reset mid-frame, then beats without sof are ignored
    beat4(1'b1, 1'b0, 32'h12345678, 4'hF, 16'h0000);
    beat4(1'b0, 1'b0, 32'h9ABCDEF0, 4'hF, 16'h0000);
    do_reset();
    beat4(1'b0, 1'b0, 32'h11112222, 4'hF, 16'h0000);
    beat4(1'b0, 1'b1, 32'h33334444, 4'hF, 16'h0000);
    idle(4);
    chk("rst_checksum", {16'd0, cs4}, 32'd0);
    chk("rst_byte_count", {16'd0, bc4}, 32'd0);
    chk("rst_csum_ok", {31'd0, ok4}, 32'd0);
    // Restarting sof discards the partial frame
    beat4(1'b1, 1'b0, 32'hDEADBEEF, 4'hF, 16'h1234);
    beat4(1'b1, 1'b1, 32'h00000001, 4'hF, 16'h0000);
    idle(3);
    chk("restart_checksum", {16'd0, cs4}, 32'h0000FFFE);
    chk("restart_byte_count", {16'd0, bc4}, 32'd4);

    // Empty eof beat
    beat4(1'b1, 1'b0, 32'h11223344, 4'hF, 16'h0000);
    beat4(1'b0, 1'b1, 32'hFFFFFFFF, 4'h0, 16'h0000);
    idle(3);
    chk("empty_eof_byte_count", {16'd0, bc4}, 32'd4);

    // Randomized frames, gaps, stray beats and partial keeps on the 4-byte instance
    for (int f = 0; f < 40; f++) begin
      nb = $urandom_range(1, 6);
      rs = 16'($urandom);
      if ($urandom_range(0, 3) == 0) beat4(1'b0, 1'($urandom), $urandom, 4'hF, 16'h0000);
      for (int b = 0; b < nb; b++) begin
        nk = $urandom_range(0, 4);
        beat4(b == 0, b == nb - 1, $urandom, top_keep(nk), rs);
        if ($urandom_range(0, 3) == 0 && b != nb - 1) idle(1);
      end
      if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 2));
    end
    idle(4);

    // Randomized frames on the 1-byte instance
    for (int f = 0; f < 10; f++) begin
      nb = $urandom_range(1, 9);
      rs = 16'($urandom);
      for (int b = 0; b < nb; b++) begin
        beat1(b == 0, b == nb - 1, 8'($urandom), 1'($urandom_range(0, 4) != 0), rs);
      end
      idle($urandom_range(0, 1));
    end
    idle(4);

    chk("pending_strobes", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
